sram_stream_reader: RTL and testbench

- Read-side sequencer for the on-chip SRAM storage block.
- Drives the SRAM address, captures the combinational read data and streams words to the downstream PE/consumer over a valid/ready handshake.
- Implements strided bursts: base address, stride and word count are latched on a start pulse.
- Sustains one word per cycle when the consumer is always ready.

---
 rtl/sram_stream_reader_pkg.sv | 11 +
 rtl/sram_addr_gen.sv | 41 ++++
 rtl/sram_stream_reader.sv | 89 ++++++++
 tb/tb_sram_stream_reader.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_reader_pkg.sv
// Shared widths and FSM encoding for the SRAM stream reader.
package sram_stream_reader_pkg;
  localparam int ADDR_W = 7;
  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } state_t;
endpackage

// File: rtl/sram_addr_gen.sv
// Strided address register and remaining-word counter for one burst.
import sram_stream_reader_pkg::*;

module sram_addr_gen #(
  parameter int A = ADDR_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         load,
  input  logic         advance,
  input  logic [A-1:0] baseAddr,
  input  logic [A-1:0] stride,
  input  logic [A:0]   count,
  output logic [A-1:0] addr,
  output logic         last,
  output logic         empty
);
  logic [A-1:0] r_addr;
  logic [A-1:0] r_stride;
  logic [A:0]   r_rem;

  // Address add truncates to A bits, so wrap-around is silent.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_rem    <= '0;
    end else if (load) begin
      r_addr   <= baseAddr;
      r_stride <= stride;
      r_rem    <= count;
    end else if (advance) begin
      r_addr <= r_addr + r_stride;
      r_rem  <= r_rem - (A+1)'(1);
    end
  end

  assign addr  = r_addr;
  assign last  = (r_rem == (A+1)'(1));
  assign empty = (r_rem == '0);
endmodule

// File: rtl/sram_stream_reader.sv
// Strided burst reader: drives SRAM address, registers read data, streams it over valid/ready.
import sram_stream_reader_pkg::*;

module sram_stream_reader #(
  parameter int A = ADDR_W,
  parameter int W = WORD_W
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic [A-1:0] baseAddr,
  input  logic [A-1:0] stride,
  input  logic [A:0]   count,
  output logic [A-1:0] sramAddress,
  input  logic [W-1:0] sramData,
  output logic [W-1:0] outData,
  output logic         outValid,
  input  logic         outReady,
  output logic         busy,
  output logic         done
);
  state_t       r_state;
  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_done;

  logic w_start_ok;
  logic w_load;
  logic w_last;
  logic w_empty;

  assign w_start_ok = (r_state == ST_IDLE) && start && (count != '0);
  // A new word may load when the output slot is empty or being drained this edge.
  assign w_load     = (r_state == ST_STREAM) && !w_empty && (!r_valid || outReady);

  sram_addr_gen #(.A(A)) u_addr_gen (
    .CLK      (CLK),
    .RST      (RST),
    .load     (w_start_ok),
    .advance  (w_load),
    .baseAddr (baseAddr),
    .stride   (stride),
    .count    (count),
    .addr     (sramAddress),
    .last     (w_last),
    .empty    (w_empty)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (count == '0) r_done  <= 1'b1;
            else             r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (w_load) begin
            r_data  <= sramData;
            r_valid <= 1'b1;
            if (w_last) r_state <= ST_FLUSH;
          end else if (r_valid && outReady) begin
            r_valid <= 1'b0;
          end
        end
        ST_FLUSH: begin
          if (r_valid && outReady) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign outData  = r_data;
  assign outValid = r_valid;
  assign done     = r_done;
  assign busy     = (r_state != ST_IDLE);
endmodule

// File: tb/tb_sram_stream_reader.sv
// Randomized bench for sram_stream_reader against a queue-based burst model.
module tb_sram_stream_reader;
  localparam int A     = 7;
  localparam int W     = 16;
  localparam int DEPTH = 1 << A;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         start = 1'b0;
  logic [A-1:0] baseAddr = '0;
  logic [A-1:0] stride = '0;
  logic [A:0]   count = '0;
  logic [A-1:0] sramAddress;
  logic [W-1:0] sramData;
  logic [W-1:0] outData;
  logic         outValid;
  logic         outReady = 1'b1;
  logic         busy;
  logic         done;

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int           first_c, done_c;
  int           vecs = 0;
  int           errs = 0;

  assign sramData = mem[sramAddress];

  always #5 CLK = ~CLK;

  sram_stream_reader #(.A(A), .W(W)) dut (
    .CLK(CLK), .RST(RST), .start(start), .baseAddr(baseAddr), .stride(stride),
    .count(count), .sramAddress(sramAddress), .sramData(sramData), .outData(outData),
    .outValid(outValid), .outReady(outReady), .busy(busy), .done(done)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected stream: word i comes from (base + i*stride) mod depth.
  function automatic void build_exp(input int base, input int str, input int cnt);
    exp_q = {};
    for (int i = 0; i < cnt; i++) exp_q.push_back(mem[A'((base + i * str) % DEPTH)]);
  endfunction

  // Leaves the bench in the first cycle after the start edge.
  task automatic pulse_start(input int base, input int str, input int cnt);
    start = 1'b1; baseAddr = A'(base); stride = A'(str); count = (A+1)'(cnt);
    tick();
    start = 1'b0;
  endtask

  // Gathers handshaken words until done; returns at the done cycle without ticking.
  task automatic collect(input int maxc, input bit rnd);
    got_q = {}; first_c = -1; done_c = -1;
    for (int c = 1; c <= maxc; c++) begin
      outReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (outValid && outReady) begin
        got_q.push_back(outData);
        if (first_c < 0) first_c = c;
      end
      if (done) begin
        done_c = c;
        break;
      end
      tick();
    end
    outReady = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; outReady = 1'b1;
    tick(); tick();
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b exp 0", outValid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b exp 0", busy); end
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b exp 0", done); end
    vecs++; if (sramAddress !== '0) begin errs++; $display("FAIL reset_addr: got %0d exp 0", sramAddress); end
    vecs++; if (outData !== '0) begin errs++; $display("FAIL reset_data: got %0h exp 0", outData); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    build_exp(4, 1, 3);
    pulse_start(4, 1, 3);
    vecs++; if (sramAddress !== A'(4)) begin errs++; $display("FAIL basic_addr_t1: got %0d exp 4", sramAddress); end
    vecs++; if (busy !== 1'b1) begin errs++; $display("FAIL basic_busy: got %b exp 1", busy); end
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL basic_valid_t1: got %b exp 0", outValid); end
    collect(20, 1'b0);
    vecs++; if (got_q.size() != 3) begin errs++; $display("FAIL basic_len: got %0d exp 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL basic_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (first_c != 2) begin errs++; $display("FAIL basic_first_cycle: got %0d exp 2", first_c); end
    vecs++; if (done_c != 5) begin errs++; $display("FAIL basic_done_cycle: got %0d exp 5", done_c); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_at_done: got %b exp 0", busy); end
    tick();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL basic_done_width: got %b exp 0", done); end
  endtask

  task automatic test_wrap();
    build_exp(120, 5, 4);
    pulse_start(120, 5, 4);
    collect(20, 1'b0);
    vecs++; if (got_q.size() != 4) begin errs++; $display("FAIL wrap_len: got %0d exp 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL wrap_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (done_c != 6) begin errs++; $display("FAIL wrap_done_cycle: got %0d exp 6", done_c); end
    tick();
  endtask

  task automatic test_backpressure();
    int pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [W-1:0] held_d = '0;
    logic [A-1:0] held_a = '0;
    bit stalled = 1'b0;
    bit saw_done = 1'b0;
    int hs = 0;
    build_exp(10, 3, 4);
    pulse_start(10, 3, 4);
    for (int c = 1; c <= 40; c++) begin
      outReady = (c <= 7) ? 1'(pat[c-1]) : 1'b1;
      if (stalled) begin
        vecs++; if (outValid !== 1'b1) begin errs++; $display("FAIL bp_valid_drop c%0d: got %b exp 1", c, outValid); end
        vecs++; if (outData !== held_d) begin errs++; $display("FAIL bp_data_hold c%0d: got %0h exp %0h", c, outData, held_d); end
        vecs++; if (sramAddress !== held_a) begin errs++; $display("FAIL bp_addr_hold c%0d: got %0d exp %0d", c, sramAddress, held_a); end
      end
      if (done) begin
        vecs++; if (hs != 4) begin errs++; $display("FAIL bp_done_early: got %0d handshakes exp 4", hs); end
        saw_done = 1'b1;
        break;
      end
      if (outValid && outReady) begin
        vecs++;
        if (hs >= 4 || outData !== exp_q[hs % 4]) begin
          errs++; $display("FAIL bp_word%0d: got %0h exp %0h", hs, outData, exp_q[hs % 4]);
        end
        hs++;
      end
      stalled = outValid && !outReady;
      held_d = outData; held_a = sramAddress;
      tick();
    end
    outReady = 1'b1;
    vecs++; if (!saw_done) begin errs++; $display("FAIL bp_timeout: got no done exp done"); end
    vecs++; if (hs != 4) begin errs++; $display("FAIL bp_handshakes: got %0d exp 4", hs); end
    tick();
  endtask

  task automatic test_count0();
    pulse_start(5, 1, 0);
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL c0_done: got %b exp 1", done); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL c0_busy: got %b exp 0", busy); end
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL c0_valid: got %b exp 0", outValid); end
    tick();
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL c0_done_width: got %b exp 0", done); end
    vecs++; if (busy !== 1'b0 || outValid !== 1'b0) begin errs++; $display("FAIL c0_idle: got busy %b valid %b exp 0 0", busy, outValid); end
  endtask

  task automatic test_start_busy();
    int dones = 0;
    int dc = -1;
    got_q = {};
    build_exp(20, 2, 5);
    pulse_start(20, 2, 5);
    outReady = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      start = (c == 3);
      if (c == 3) begin baseAddr = A'(50); stride = A'(1); count = (A+1)'(7); end
      if (outValid && outReady) got_q.push_back(outData);
      if (done) begin dones++; dc = c; end
      tick();
    end
    start = 1'b0;
    vecs++; if (got_q.size() != 5) begin errs++; $display("FAIL sb_len: got %0d exp 5", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL sb_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (dones != 1) begin errs++; $display("FAIL sb_done_count: got %0d exp 1", dones); end
    vecs++; if (dc != 7) begin errs++; $display("FAIL sb_done_cycle: got %0d exp 7", dc); end
  endtask

  task automatic test_reset_mid();
    build_exp(30, 1, 6);
    pulse_start(30, 1, 6);
    outReady = 1'b1;
    tick();
    vecs++; if (outValid !== 1'b1 || outData !== exp_q[0]) begin errs++; $display("FAIL rm_word0: got %b/%0h exp 1/%0h", outValid, outData, exp_q[0]); end
    tick();
    vecs++; if (outValid !== 1'b1 || outData !== exp_q[1]) begin errs++; $display("FAIL rm_word1: got %b/%0h exp 1/%0h", outValid, outData, exp_q[1]); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    vecs++; if (outValid !== 1'b0) begin errs++; $display("FAIL rm_valid: got %b exp 0", outValid); end
    vecs++; if (busy !== 1'b0) begin errs++; $display("FAIL rm_busy: got %b exp 0", busy); end
    vecs++; if (sramAddress !== '0) begin errs++; $display("FAIL rm_addr: got %0d exp 0", sramAddress); end
    for (int c = 0; c < 5; c++) begin
      vecs++; if (done !== 1'b0 || outValid !== 1'b0) begin errs++; $display("FAIL rm_quiet%0d: got done %b valid %b exp 0 0", c, done, outValid); end
      tick();
    end
    build_exp(0, 1, 2);
    pulse_start(0, 1, 2);
    collect(20, 1'b0);
    vecs++; if (got_q.size() != 2) begin errs++; $display("FAIL rm_new_len: got %0d exp 2", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 2; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rm_new_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    tick();
  endtask

  task automatic test_boundaries();
    int b;
    // stride 0: same word repeated
    b = 9;
    build_exp(b, 0, 3);
    pulse_start(b, 0, 3);
    collect(20, 1'b0);
    vecs++; if (got_q.size() != 3) begin errs++; $display("FAIL s0_len: got %0d exp 3", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL s0_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (sramAddress !== A'(b)) begin errs++; $display("FAIL s0_addr: got %0d exp %0d", sramAddress, b); end
    tick();
    // full-depth burst wraps back to base
    b = $urandom_range(0, DEPTH - 1);
    build_exp(b, 1, DEPTH);
    pulse_start(b, 1, DEPTH);
    collect(300, 1'b0);
    vecs++; if (got_q.size() != DEPTH) begin errs++; $display("FAIL full_len: got %0d exp %0d", got_q.size(), DEPTH); end
    for (int i = 0; i < got_q.size() && i < DEPTH; i++) begin
      vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL full_word%0d: got %0h exp %0h", i, got_q[i], exp_q[i]); end
    end
    vecs++; if (done_c != DEPTH + 2) begin errs++; $display("FAIL full_done_cycle: got %0d exp %0d", done_c, DEPTH + 2); end
    vecs++; if (sramAddress !== A'(b)) begin errs++; $display("FAIL full_addr_wrap: got %0d exp %0d", sramAddress, b); end
    tick();
  endtask

  task automatic test_random();
    int b, s, n;
    for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom);
    for (int it = 0; it < 30; it++) begin
      b = $urandom_range(0, DEPTH - 1);
      s = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(0, 24);
      build_exp(b, s, n);
      pulse_start(b, s, n);
      collect(400, 1'b1);
      vecs++; if (done_c < 0) begin errs++; $display("FAIL rnd%0d_timeout: got no done exp done", it); end
      vecs++; if (got_q.size() != n) begin errs++; $display("FAIL rnd%0d_len: got %0d exp %0d", it, got_q.size(), n); end
      for (int i = 0; i < got_q.size() && i < n; i++) begin
        vecs++; if (got_q[i] !== exp_q[i]) begin errs++; $display("FAIL rnd%0d_word%0d: got %0h exp %0h", it, i, got_q[i], exp_q[i]); end
      end
      tick();
      vecs++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL rnd%0d_post: got done %b busy %b exp 0 0", it, done, busy); end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = W'(i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_count0();
    test_start_busy();
    test_reset_mid();
    test_boundaries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
